a25_copro_master: RTL and testbench
===================================

Name: a25_copro_master

Overview:
- Initiator side of the CP15 coprocessor interface (MCR/MRC bus) for the Amber 25 core.
- Lets a debug or configuration agent issue single CP15 register reads and writes over a valid/ready request port.
- Shares the copro bus with the core's own copro outputs. The core always has priority; the master fills idle, unstalled cycles.
- Sits between the core's copro outputs and the CP15 coprocessor. It returns read data captured from the coprocessor's registered read port.

Parameters:
- BOOT_CACHEABLE_AREA, 32'h0000_0001, value written to CP15 reg 3 at boot (used only with A25_COPRO_BOOT_INIT_EN).
- BOOT_CACHE_CONTROL, 3'b001, value written to CP15 reg 2 at boot (used only with A25_COPRO_BOOT_INIT_EN).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_core_stall  in  1  core stall; the coprocessor ignores the bus while it is high
- i_core_copro_opcode1  in  3  core-side opcode1
- i_core_copro_opcode2  in  3  core-side opcode2
- i_core_copro_crn  in  4  core-side CRn
- i_core_copro_crm  in  4  core-side CRm
- i_core_copro_num  in  4  core-side coprocessor number
- i_core_copro_operation  in  2  core-side op: 0 none, 1 MRC read, 2 MCR write
- i_core_copro_write_data  in  32  core-side write data
- o_copro_opcode1  out  3  muxed to coprocessor
- o_copro_opcode2  out  3  muxed to coprocessor
- o_copro_crn  out  4  muxed to coprocessor
- o_copro_crm  out  4  muxed to coprocessor
- o_copro_num  out  4  muxed to coprocessor
- o_copro_operation  out  2  muxed to coprocessor
- o_copro_write_data  out  32  muxed to coprocessor
- i_copro_read_data  in  32  coprocessor registered read data
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_req_write  in  1  1 = MCR write, 0 = MRC read
- i_req_crn  in  4  target CP15 register
- i_req_wdata  in  32  write data
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_rdata  out  32  read data (0 for writes)
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: i_rst_n, asynchronous, active-low; clock i_clk.
  - Reset forces state IDLE, o_rsp_valid=0, o_rsp_rdata=0 and clears the latched request registers.
  - Reset asserted mid-operation aborts the operation with no response.
- States: IDLE, ISSUE, CAPTURE (plus BOOT_AREA, BOOT_CTRL with the optional feature).
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, latch write/crn/wdata and go to ISSUE. The request is accepted the same cycle.
- ISSUE:
  - grant = !i_core_stall && i_core_copro_operation==0.
  - While grant is low, stay in ISSUE and hold the request. The core is never blocked.
  - On grant, drive the master fields combinationally for that cycle: opcode1=0, opcode2=0, crm=0, num=4'd15, crn=latched, operation=2 (write) or 1 (read), write_data=latched (0 for reads). Then go to CAPTURE.
- CAPTURE:
  - The coprocessor read register now reflects the master's CRn. It updates only on unstalled edges, so it is valid regardless of i_core_stall.
  - At the end of the cycle: o_rsp_rdata <= read ? i_copro_read_data : 0, o_rsp_valid <= 1, next state IDLE.
- o_rsp_valid: registered; high exactly one cycle, coinciding with the IDLE cycle.
  - A new request may be accepted in the same cycle as o_rsp_valid.
- Latency with no contention: accept cycle 0, issue cycle 1, capture cycle 2, o_rsp_valid cycle 3.
- Mux: o_copro_* carry the master fields only in the granted ISSUE cycle. In every other cycle, including reset, all core inputs pass through unchanged.
- Core MRC data integrity: the master drives its CRn only in the granted cycle, so a core MRC issued in the preceding cycle still sees its own read data.
- The block has no internal queue. Back-pressure is provided by o_req_ready alone.

Optional Feature:
- Macro: A25_COPRO_BOOT_INIT_EN.
- Defined:
  - After reset the FSM starts in BOOT_AREA: an MCR write of BOOT_CACHEABLE_AREA to crn 3.
  - It then moves to BOOT_CTRL: an MCR write of {29'd0, BOOT_CACHE_CONTROL} to crn 2, then IDLE.
  - Each boot write uses the same grant rule as ISSUE.
  - o_req_ready=0 and o_busy=1 during boot; no o_rsp_valid is produced for boot writes.
- Undefined: reset state is IDLE and o_req_ready=1 in the first cycle after reset release.

Test Plan:
- Read ID: req read crn=0, core idle, no stall -> cycle 1 o_copro_operation=1, crn=0, num=15; cycle 3 o_rsp_valid=1, o_rsp_rdata=32'h4156_0300.
- Write then read: write crn=3 wdata=32'h0000_00F0 -> o_rsp_valid with rdata 0; read crn=3 -> rdata 32'h0000_00F0.
- Core priority: core operation=2, crn=1 held for 3 cycles during ISSUE -> outputs equal core inputs for those cycles; master issues in cycle 4; response 2 cycles later.
- Stall: i_core_stall high 2 cycles in ISSUE -> issue delayed 2 cycles. i_core_stall high in CAPTURE -> read of crn=0 still returns 32'h4156_0300.
- Reset in CAPTURE -> no o_rsp_valid; o_req_ready=1 in the first cycle after release (without the macro); the next request completes normally.
- With A25_COPRO_BOOT_INIT_EN: after reset, the first master issues are write crn 3 = 32'h0000_0001 then write crn 2 = 32'h0000_0001; o_req_ready stays 0 until both complete.

Source files
------------

// File: rtl/a25_copro_master.sv
// CP15 copro-bus initiator for the Amber 25: issues single MCR/MRC requests in idle core cycles.
// Optional boot-time cache setup writes are enabled by defining A25_COPRO_BOOT_INIT_EN.
module a25_copro_master #(
  parameter logic [31:0] BOOT_CACHEABLE_AREA = 32'h0000_0001,
  parameter logic [2:0]  BOOT_CACHE_CONTROL  = 3'b001
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_core_stall,
  input  logic [2:0]  i_core_copro_opcode1,
  input  logic [2:0]  i_core_copro_opcode2,
  input  logic [3:0]  i_core_copro_crn,
  input  logic [3:0]  i_core_copro_crm,
  input  logic [3:0]  i_core_copro_num,
  input  logic [1:0]  i_core_copro_operation,
  input  logic [31:0] i_core_copro_write_data,
  output logic [2:0]  o_copro_opcode1,
  output logic [2:0]  o_copro_opcode2,
  output logic [3:0]  o_copro_crn,
  output logic [3:0]  o_copro_crm,
  output logic [3:0]  o_copro_num,
  output logic [1:0]  o_copro_operation,
  output logic [31:0] o_copro_write_data,
  input  logic [31:0] i_copro_read_data,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [3:0]  i_req_crn,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_busy
);

  localparam logic [1:0] OP_MRC = 2'd1;
  localparam logic [1:0] OP_MCR = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_BOOT_AREA,
    ST_BOOT_CTRL
  } state_t;

`ifdef A25_COPRO_BOOT_INIT_EN
  localparam state_t RESET_STATE = ST_BOOT_AREA;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t      state_reg, state_next;
  logic        req_write_reg;
  logic [3:0]  req_crn_reg;
  logic [31:0] req_wdata_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;

  logic        grant;
  logic        load_req;
  logic        capture;
  logic        mst_sel;
  logic [3:0]  mst_crn;
  logic [1:0]  mst_op;
  logic [31:0] mst_wdata;

  // The core owns the bus whenever it is stalled or has an operation of its own.
  assign grant = !i_core_stall && (i_core_copro_operation == 2'd0);

  always_comb begin
    state_next = state_reg;
    load_req   = 1'b0;
    capture    = 1'b0;
    mst_sel    = 1'b0;
    mst_crn    = 4'd0;
    mst_op     = 2'd0;
    mst_wdata  = 32'd0;
    case (state_reg)
      ST_IDLE: begin
        if (i_req_valid) begin
          load_req   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (grant) begin
          mst_sel    = 1'b1;
          mst_crn    = req_crn_reg;
          mst_op     = req_write_reg ? OP_MCR : OP_MRC;
          mst_wdata  = req_write_reg ? req_wdata_reg : 32'd0;
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = ST_IDLE;
      end
      ST_BOOT_AREA: begin
        if (grant) begin
          mst_sel    = 1'b1;
          mst_crn    = 4'd3;
          mst_op     = OP_MCR;
          mst_wdata  = BOOT_CACHEABLE_AREA;
          state_next = ST_BOOT_CTRL;
        end
      end
      ST_BOOT_CTRL: begin
        if (grant) begin
          mst_sel    = 1'b1;
          mst_crn    = 4'd2;
          mst_op     = OP_MCR;
          mst_wdata  = {29'd0, BOOT_CACHE_CONTROL};
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= RESET_STATE;
      req_write_reg <= 1'b0;
      req_crn_reg   <= 4'd0;
      req_wdata_reg <= 32'd0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= capture;
      if (load_req) begin
        req_write_reg <= i_req_write;
        req_crn_reg   <= i_req_crn;
        req_wdata_reg <= i_req_wdata;
      end
      // The coprocessor read register only moves on unstalled edges, so it is safe to sample here.
      if (capture)
        rsp_rdata_reg <= req_write_reg ? 32'd0 : i_copro_read_data;
    end
  end

  assign o_copro_opcode1    = mst_sel ? 3'd0  : i_core_copro_opcode1;
  assign o_copro_opcode2    = mst_sel ? 3'd0  : i_core_copro_opcode2;
  assign o_copro_crn        = mst_sel ? mst_crn : i_core_copro_crn;
  assign o_copro_crm        = mst_sel ? 4'd0  : i_core_copro_crm;
  assign o_copro_num        = mst_sel ? 4'd15 : i_core_copro_num;
  assign o_copro_operation  = mst_sel ? mst_op : i_core_copro_operation;
  assign o_copro_write_data = mst_sel ? mst_wdata : i_core_copro_write_data;

  assign o_req_ready = (state_reg == ST_IDLE);
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_a25_copro_master.sv
// Self-checking bench for a25_copro_master with a small CP15 register-file model on the copro bus.
`timescale 1ns/1ps
module tb_a25_copro_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_stall = 1'b0;
  logic [2:0]  core_opcode1 = 3'd0;
  logic [2:0]  core_opcode2 = 3'd0;
  logic [3:0]  core_crn = 4'd0;
  logic [3:0]  core_crm = 4'd0;
  logic [3:0]  core_num = 4'd0;
  logic [1:0]  core_op = 2'd0;
  logic [31:0] core_wdata = 32'd0;
  logic [2:0]  copro_opcode1, copro_opcode2;
  logic [3:0]  copro_crn, copro_crm, copro_num;
  logic [1:0]  copro_op;
  logic [31:0] copro_wdata;
  logic [31:0] copro_rdata;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_crn = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_crn3;

  always #5 clk = ~clk;

  a25_copro_master dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_core_stall(core_stall),
    .i_core_copro_opcode1(core_opcode1), .i_core_copro_opcode2(core_opcode2),
    .i_core_copro_crn(core_crn), .i_core_copro_crm(core_crm), .i_core_copro_num(core_num),
    .i_core_copro_operation(core_op), .i_core_copro_write_data(core_wdata),
    .o_copro_opcode1(copro_opcode1), .o_copro_opcode2(copro_opcode2),
    .o_copro_crn(copro_crn), .o_copro_crm(copro_crm), .o_copro_num(copro_num),
    .o_copro_operation(copro_op), .o_copro_write_data(copro_wdata),
    .i_copro_read_data(copro_rdata),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_crn(req_crn), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_busy(busy)
  );

  // CP15 stand-in: reg 0 is the read-only ID, read data registered on unstalled edges.
  logic        cp_rst = 1'b1;
  logic [31:0] cp_regs [16];
  always @(posedge clk) begin
    if (cp_rst) begin
      for (int i = 0; i < 16; i++) cp_regs[i] <= (i == 0) ? 32'h4156_0300 : 32'd0;
      copro_rdata <= 32'd0;
    end else if (!core_stall) begin
      if (copro_op == 2'd2 && copro_num == 4'd15 && copro_crn != 4'd0)
        cp_regs[copro_crn] <= copro_wdata;
      copro_rdata <= cp_regs[copro_crn];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        $display("rsp: rdata=%h expected=%h", rsp_rdata, e);
        check_val("rsp_rdata", rsp_rdata, e);
      end
    end
  end

  // Drives a request until it is accepted; returns just after the accepting edge (issue cycle).
  task automatic send(input logic w, input logic [3:0] crn, input logic [31:0] wd,
                      input logic [31:0] exp);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_crn = crn; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 50) begin n++; @(negedge clk); end
    check_val("accept", {31'd0, req_ready}, 32'd1);
    if (req_ready) sb.push_back(exp);
    $display("req: write=%0d crn=%0d wdata=%h", w, crn, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin n++; @(negedge clk); end
    check_val("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_master_issue(input string tag, input logic [1:0] op, input logic [3:0] crn,
                                    input logic [31:0] wd);
    check_val({tag, "_op"}, {30'd0, copro_op}, {30'd0, op});
    check_val({tag, "_crn"}, {28'd0, copro_crn}, {28'd0, crn});
    check_val({tag, "_fields"}, {20'd0, copro_num, copro_crm, copro_opcode1, copro_opcode2},
              {20'd0, 4'd15, 4'd0, 3'd0, 3'd0});
    check_val({tag, "_wdata"}, copro_wdata, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    core_opcode1 = 3'd5; core_opcode2 = 3'd2; core_crm = 4'd7; core_num = 4'd15;
    core_crn = 4'd9; core_wdata = 32'h1234_5678;
    @(posedge clk); #1; cp_rst = 1'b0;
    @(negedge clk);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_val("rst_passthru", {16'd0, copro_opcode1, copro_opcode2, copro_crm, copro_crn, copro_op},
              {16'd0, 3'd5, 3'd2, 4'd7, 4'd9, 2'd0});
    check_val("rst_pass_wdata", copro_wdata, 32'h1234_5678);
    core_opcode1 = 3'd0; core_opcode2 = 3'd0; core_crm = 4'd0; core_num = 4'd0;
    core_crn = 4'd0; core_wdata = 32'd0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
`ifdef A25_COPRO_BOOT_INIT_EN
    check_val("boot_ready_low", {31'd0, req_ready}, 32'd0);
    begin
      int n = 0;
      while (!req_ready && n < 50) begin n++; @(negedge clk); end
    end
    check_val("boot_reg3", cp_regs[3], 32'h0000_0001);
    check_val("boot_reg2", cp_regs[2], 32'h0000_0001);
`else
    check_val("ready_after_rst", {31'd0, req_ready}, 32'd1);
    check_val("idle_not_busy", {31'd0, busy}, 32'd0);
`endif
    @(posedge clk); #1;

    // Read ID with exact latency
    send(1'b0, 4'd0, 32'd0, 32'h4156_0300);
    @(negedge clk); check_master_issue("id_issue", 2'd1, 4'd0, 32'd0);
    check_val("id_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); check_val("id_c2_rsp", {31'd0, rsp_valid}, 32'd0);
    check_val("id_c2_pass", {30'd0, copro_op}, 32'd0);
    @(negedge clk); check_val("id_c3_rsp", {31'd0, rsp_valid}, 32'd1);
    check_val("id_c3_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Write then read back
    send(1'b1, 4'd3, 32'h0000_00F0, 32'd0);
    @(negedge clk); check_master_issue("wr_issue", 2'd2, 4'd3, 32'h0000_00F0);
    @(posedge clk); #1;
    wait_rsp();
    send(1'b0, 4'd3, 32'd0, 32'h0000_00F0);
    wait_rsp();

    // Core priority: core MCR to crn 1 held for three issue cycles
    send(1'b0, 4'd0, 32'd0, 32'h4156_0300);
    core_op = 2'd2; core_crn = 4'd1; core_num = 4'd15; core_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("prio_op", {30'd0, copro_op}, 32'd2);
      check_val("prio_crn", {28'd0, copro_crn}, 32'd1);
      check_val("prio_wdata", copro_wdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    core_op = 2'd0; core_crn = 4'd0; core_num = 4'd0; core_wdata = 32'd0;
    @(negedge clk); check_master_issue("prio_issue", 2'd1, 4'd0, 32'd0);
    @(negedge clk); check_val("prio_c5_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); check_val("prio_c6_rsp", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    check_val("core_wrote_reg1", cp_regs[1], 32'hDEAD_BEEF);

    // Stall during issue delays the issue by two cycles
    send(1'b0, 4'd3, 32'd0, 32'h0000_00F0);
    core_stall = 1'b1;
    @(negedge clk); check_val("stall_c1_pass", {30'd0, copro_op}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check_val("stall_c2_pass", {30'd0, copro_op}, 32'd0);
    @(posedge clk); #1; core_stall = 1'b0;
    @(negedge clk); check_master_issue("stall_issue", 2'd1, 4'd3, 32'd0);
    @(negedge clk); check_val("stall_c4_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); check_val("stall_c5_rsp", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;

    // Stall during capture must not corrupt the read data
    send(1'b0, 4'd0, 32'd0, 32'h4156_0300);
    @(posedge clk); #1; core_stall = 1'b1;
    @(negedge clk); check_val("cap_stall_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1; core_stall = 1'b0;
    @(negedge clk); check_val("cap_stall_c3_rsp", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;

    // Reset during capture aborts with no response
    send(1'b0, 4'd0, 32'd0, 32'h4156_0300);
    @(posedge clk); #1; rst_n = 1'b0; sb.delete();
    @(negedge clk); check_val("abort_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); check_val("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
`ifdef A25_COPRO_BOOT_INIT_EN
    check_val("abort_boot_busy", {31'd0, busy}, 32'd1);
    exp_crn3 = 32'h0000_0001;
`else
    check_val("abort_ready", {31'd0, req_ready}, 32'd1);
    exp_crn3 = 32'h0000_00F0;
`endif
    @(posedge clk); #1;
    send(1'b0, 4'd3, 32'd0, exp_crn3);
    wait_rsp();

    repeat (3) @(negedge clk);
    check_val("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
